// File: rtl/conv_mac_engine.sv
`default_nettype none
// ============================================================================
// conv_mac_engine : multi-channel KNL_HEIGHT x KNL_WIDTH fixed-point conv MAC,
// 2-stage pipeline, valid/ready output. Option macro: CONV_SAT_EN (saturate).
// Revision: 1.0
// ============================================================================
module conv_mac_engine #(
  parameter int  DATA_WIDTH = 32,
  parameter int  FRAC_BITS  = 16,
  parameter int  KNL_WIDTH  = 5,
  parameter int  KNL_HEIGHT = 5,
  parameter int  KNL_MAXNUM = 16,
  localparam int KSIZE      = KNL_WIDTH * KNL_HEIGHT,
  localparam int CW         = $clog2(KNL_MAXNUM + 1)
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  clear,
  input  logic                  ld_knl_valid,
  input  logic [DATA_WIDTH-1:0] ld_knl_data,
  output logic                  ld_knl_ready,
  input  logic                  ld_win_valid,
  input  logic [DATA_WIDTH-1:0] ld_win_data,
  output logic                  ld_win_ready,
  input  logic [CW-1:0]         num_knls,
  input  logic                  start,
  output logic                  start_err,
  input  logic                  acc_en,
  input  logic [DATA_WIDTH-1:0] psum_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CW-1:0]         out_chnl,
  output logic                  busy
);
  localparam int c_knl_words = KNL_MAXNUM * KSIZE;
  localparam int c_kcw       = $clog2(c_knl_words + 1);
  localparam int c_wcw       = $clog2(KSIZE + 1);
  localparam int c_pw        = 2 * DATA_WIDTH;
  localparam int c_nw        = c_kcw + CW;
  localparam logic [c_kcw-1:0] c_knl_full = c_kcw'(c_knl_words);
  localparam logic [c_wcw-1:0] c_win_full = c_wcw'(KSIZE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  logic [c_kcw-1:0]      r_knl_cnt;
  logic [c_wcw-1:0]      r_win_cnt;
  logic [CW-1:0]         r_ch;
  logic [CW-1:0]         r_n;
  logic [CW-1:0]         r_s1_chnl;
  logic [CW-1:0]         r_out_chnl;
  logic                  r_s1_valid;
  logic                  r_out_valid;
  logic                  r_start_err;
  logic [DATA_WIDTH-1:0] r_mac;
  logic [DATA_WIDTH-1:0] r_knl_mem [c_knl_words];
  logic [DATA_WIDTH-1:0] r_win     [KSIZE];
  logic [DATA_WIDTH-1:0] r_prod    [KSIZE];
  logic [DATA_WIDTH-1:0] w_prod    [KSIZE];

  logic                   w_stall;
  logic                   w_issue;
  logic                   w_knl_fire;
  logic                   w_win_fire;
  logic                   w_start_ok;
  logic [c_nw-1:0]        w_need;
  logic [c_kcw-1:0]       w_kbase;
  logic signed [c_pw-1:0] w_sum;
  logic signed [c_pw-1:0] w_acc;
  logic [DATA_WIDTH-1:0]  w_mac;

`ifdef CONV_SAT_EN
  localparam logic signed [c_pw-1:0] c_max = c_pw'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [c_pw-1:0] c_min = ~c_max;

  function automatic logic [DATA_WIDTH-1:0] sat_dw(input logic signed [c_pw-1:0] v);
    if (v > c_max) return c_max[DATA_WIDTH-1:0];
    if (v < c_min) return c_min[DATA_WIDTH-1:0];
    return v[DATA_WIDTH-1:0];
  endfunction
`endif

  assign busy         = (r_state != S_IDLE);
  assign ld_win_ready = (r_state == S_IDLE);
  assign ld_knl_ready = (r_state == S_IDLE) && (r_knl_cnt < c_knl_full);
  assign out_valid    = r_out_valid;
  assign out_chnl     = r_out_chnl;
  assign start_err    = r_start_err;

  assign w_stall    = r_out_valid && !out_ready;
  assign w_issue    = (r_state == S_RUN) && !w_stall;
  assign w_knl_fire = ld_knl_valid && ld_knl_ready && !clear;
  assign w_win_fire = ld_win_valid && ld_win_ready && !clear;
  assign w_need     = c_nw'(num_knls) * c_nw'(KSIZE);
  assign w_start_ok = (r_win_cnt == c_win_full) && (num_knls != '0) &&
                      (w_need <= c_nw'(r_knl_cnt));
  assign w_kbase    = c_kcw'(r_ch) * c_kcw'(KSIZE);

  // Kernel word k is row-major (r*W+c); window slot is column-major (c*H+r).
  generate
    for (genvar r = 0; r < KNL_HEIGHT; r++) begin : g_row
      for (genvar c = 0; c < KNL_WIDTH; c++) begin : g_col
        localparam int c_k = r * KNL_WIDTH + c;
        localparam int c_w = c * KNL_HEIGHT + r;
        logic signed [c_pw-1:0] w_full;
        assign w_full = (c_pw'($signed(r_knl_mem[w_kbase + c_kcw'(c_k)])) *
                         c_pw'($signed(r_win[c_w]))) >>> FRAC_BITS;
`ifdef CONV_SAT_EN
        assign w_prod[c_k] = sat_dw(w_full);
`else
        logic w_unused_hi;
        assign w_prod[c_k] = w_full[DATA_WIDTH-1:0];
        assign w_unused_hi = ^w_full[c_pw-1:DATA_WIDTH];
`endif
      end
    end
  endgenerate

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < KSIZE; i++) w_sum = w_sum + c_pw'($signed(r_prod[i]));
  end

  assign w_acc = c_pw'($signed(r_mac)) + (acc_en ? c_pw'($signed(psum_in)) : c_pw'(0));

`ifdef CONV_SAT_EN
  assign w_mac    = sat_dw(w_sum);
  assign out_data = sat_dw(w_acc);
`else
  logic w_unused_sum;
  assign w_mac        = w_sum[DATA_WIDTH-1:0];
  assign out_data     = w_acc[DATA_WIDTH-1:0];
  assign w_unused_sum = ^{w_sum[c_pw-1:DATA_WIDTH], w_acc[c_pw-1:DATA_WIDTH]};
`endif

  // Storage and stage-1 product registers carry no reset.
  always_ff @(posedge clk) begin
    if (w_knl_fire) r_knl_mem[r_knl_cnt] <= ld_knl_data;
    if (w_win_fire) begin
      for (int i = 0; i < KSIZE - 1; i++) r_win[i] <= r_win[i+1];
      r_win[KSIZE-1] <= ld_win_data;
    end
    if (w_issue) begin
      for (int i = 0; i < KSIZE; i++) r_prod[i] <= w_prod[i];
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      r_state     <= S_IDLE;
      r_knl_cnt   <= '0;
      r_win_cnt   <= '0;
      r_ch        <= '0;
      r_n         <= '0;
      r_s1_chnl   <= '0;
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_chnl  <= '0;
      r_mac       <= '0;
      r_start_err <= 1'b0;
    end else if (clear) begin
      r_state     <= S_IDLE;
      r_knl_cnt   <= '0;
      r_win_cnt   <= '0;
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_start_err <= 1'b0;
    end else begin
      r_start_err <= 1'b0;
      if (w_knl_fire) r_knl_cnt <= r_knl_cnt + c_kcw'(1);
      if (w_win_fire && (r_win_cnt != c_win_full)) r_win_cnt <= r_win_cnt + c_wcw'(1);
      if (!w_stall) begin
        r_s1_valid  <= 1'b0;
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_mac      <= w_mac;
          r_out_chnl <= r_s1_chnl;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_start_ok) begin
              r_state <= S_RUN;
              r_ch    <= '0;
              r_n     <= num_knls;
            end else begin
              r_start_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!w_stall) begin
            r_s1_valid <= 1'b1;
            r_s1_chnl  <= r_ch;
            r_ch       <= r_ch + CW'(1);
            if (r_ch == r_n - CW'(1)) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_out_valid && out_ready && (r_out_chnl == r_n - CW'(1))) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_mac_engine.sv
`default_nettype none
// ============================================================================
// tb_conv_mac_engine : directed + randomized bench with arithmetic reference
// model for conv_mac_engine (honours CONV_SAT_EN). Revision: 1.0
// ============================================================================
module tb_conv_mac_engine;
  localparam int DW = 32;
  localparam int FB = 16;
  localparam int KW = 5;
  localparam int KH = 5;
  localparam int KM = 16;
  localparam int KS = KW * KH;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          srstn;
  logic          clear;
  logic          ld_knl_valid;
  logic [DW-1:0] ld_knl_data;
  logic          ld_knl_ready;
  logic          ld_win_valid;
  logic [DW-1:0] ld_win_data;
  logic          ld_win_ready;
  logic [CW-1:0] num_knls;
  logic          start;
  logic          start_err;
  logic          acc_en;
  logic [DW-1:0] psum_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_chnl;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] km[$];
  logic [DW-1:0] wm[$];
  logic [DW-1:0] obs_q[$];
  logic [DW-1:0] ps_tab [KM];

  always #5 clk = ~clk;

  conv_mac_engine #(
    .DATA_WIDTH(DW), .FRAC_BITS(FB), .KNL_WIDTH(KW), .KNL_HEIGHT(KH), .KNL_MAXNUM(KM)
  ) dut (
    .clk(clk), .srstn(srstn), .clear(clear),
    .ld_knl_valid(ld_knl_valid), .ld_knl_data(ld_knl_data), .ld_knl_ready(ld_knl_ready),
    .ld_win_valid(ld_win_valid), .ld_win_data(ld_win_data), .ld_win_ready(ld_win_ready),
    .num_knls(num_knls), .start(start), .start_err(start_err),
    .acc_en(acc_en), .psum_in(psum_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chnl(out_chnl), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

`ifdef CONV_SAT_EN
  function automatic longint sat32(input longint v);
    if (v > 64'sh7FFFFFFF) return 64'sh7FFFFFFF;
    if (v < -64'sh80000000) return -64'sh80000000;
    return v;
  endfunction
`endif

  // Dot product of kernel ch with the newest KS window words.
  function automatic logic [DW-1:0] model_out(input int ch, input bit acc, input logic [DW-1:0] ps);
    longint sum, kv, wv, p;
    logic [DW-1:0] t;
    int base;
    base = wm.size() - KS;
    sum = 0;
    for (int r = 0; r < KH; r++) begin
      for (int c = 0; c < KW; c++) begin
        kv = longint'($signed(km[ch*KS + r*KW + c]));
        wv = longint'($signed(wm[base + c*KH + r]));
        p = (kv * wv) >>> FB;
`ifdef CONV_SAT_EN
        p = sat32(p);
`else
        t = p[DW-1:0];
        p = longint'($signed(t));
`endif
        sum += p;
      end
    end
`ifdef CONV_SAT_EN
    sum = sat32(sum);
    if (acc) sum = sat32(sum + longint'($signed(ps)));
`else
    if (acc) sum += longint'($signed(ps));
`endif
    t = sum[DW-1:0];
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_knl(input logic [DW-1:0] d);
    ld_knl_valid = 1'b1;
    ld_knl_data  = d;
    if (km.size() < KM*KS) km.push_back(d);
    tick();
    ld_knl_valid = 1'b0;
  endtask

  task automatic load_win(input logic [DW-1:0] d);
    ld_win_valid = 1'b1;
    ld_win_data  = d;
    wm.push_back(d);
    tick();
    ld_win_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    km.delete();
    wm.delete();
  endtask

  task automatic fill_ps_random();
    for (int i = 0; i < KM; i++) ps_tab[i] = $urandom;
  endtask

  // mode 0: always ready, 1: random ready, 2: ready low for first 4 valid cycles
  task automatic run_pass(input int n, input bit acc, input int mode);
    int got, vcnt, first;
    logic [DW-1:0] exp;
    obs_q.delete();
    got = 0; vcnt = 0; first = -1;
    acc_en    = acc;
    num_knls  = CW'(n);
    out_ready = 1'b1;
    psum_in   = ps_tab[0];
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 300 && got < n; cyc++) begin
      @(posedge clk);
      #1;
      psum_in = ps_tab[got];
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (vcnt < 4) ? 1'b0 : 1'b1;
      endcase
      #1;
      if (out_valid) begin
        if (first < 0) begin
          first = cyc;
          check("first_valid_latency", 64'(cyc), 64'd2);
        end
        exp = model_out(got, acc, ps_tab[got]);
        check("out_data", out_data, exp);
        check("out_chnl", out_chnl, 64'(got));
        vcnt++;
        if (out_ready) begin
          obs_q.push_back(out_data);
          got++;
        end
      end
    end
    check("outputs_received", 64'(got), 64'(n));
    tick();
    check("busy_after_last", busy, 1'b0);
    check("valid_after_last", out_valid, 1'b0);
    acc_en = 1'b0;
  endtask

  task automatic expect_start_err(input int n, input string tag);
    num_knls = CW'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_err_pulse"}, start_err, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    tick();
    check({tag, "_err_cleared"}, start_err, 1'b0);
    check({tag, "_no_valid"}, out_valid, 1'b0);
    check({tag, "_still_idle"}, busy, 1'b0);
  endtask

  initial begin
    srstn = 1'b0; clear = 1'b0; start = 1'b0; acc_en = 1'b0; out_ready = 1'b1;
    ld_knl_valid = 1'b0; ld_knl_data = '0; ld_win_valid = 1'b0; ld_win_data = '0;
    num_knls = '0; psum_in = '0;
    for (int i = 0; i < KM; i++) ps_tab[i] = '0;
    tick();
    tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_start_err", start_err, 1'b0);
    check("rst_out_chnl", out_chnl, '0);
    check("rst_out_data", out_data, '0);
    srstn = 1'b1;
    tick();
    check("rst_knl_ready", ld_knl_ready, 1'b1);
    check("rst_win_ready", ld_win_ready, 1'b1);

    // 1.0 kernel x 2.0 window
    for (int i = 0; i < KS; i++) load_knl(32'h0001_0000);
    for (int i = 0; i < KS; i++) load_win(32'h0002_0000);
    run_pass(1, 1'b0, 0);
    check("t1_value", obs_q[0], 32'h0032_0000);

    // -1.0 kernel x 0.5 window, then with partial sum added
    do_clear();
    for (int i = 0; i < KS; i++) load_knl(32'hFFFF_0000);
    for (int i = 0; i < KS; i++) load_win(32'h0000_8000);
    run_pass(1, 1'b0, 0);
    check("t2_value", obs_q[0], 32'hFFF3_8000);
    ps_tab[0] = 32'h000D_0000;
    run_pass(1, 1'b1, 0);
    check("t2_acc_value", obs_q[0], 32'h0000_8000);

    // three channels with backpressure
    do_clear();
    for (int k = 1; k <= 3; k++)
      for (int i = 0; i < KS; i++) load_knl(32'(k) << 16);
    for (int i = 0; i < KS; i++) load_win(32'h0001_0000);
    run_pass(3, 1'b0, 2);
    check("t3_ch0", obs_q[0], 32'h0019_0000);
    check("t3_ch1", obs_q[1], 32'h0032_0000);
    check("t3_ch2", obs_q[2], 32'h004B_0000);

    // rejected starts
    do_clear();
    for (int i = 0; i < KS; i++) load_knl($urandom);
    for (int i = 0; i < KS - 1; i++) load_win($urandom);
    expect_start_err(1, "win_not_full");
    load_win($urandom);
    expect_start_err(2, "too_many_knls");
    expect_start_err(0, "zero_knls");
    fill_ps_random();
    run_pass(1, 1'b1, 1);

    // overflow corner
    do_clear();
    for (int i = 0; i < KS; i++) load_knl(32'h7FFF_FFFF);
    for (int i = 0; i < KS; i++) load_win(32'h7FFF_FFFF);
    run_pass(1, 1'b0, 0);
`ifdef CONV_SAT_EN
    check("t5_max_value", obs_q[0], 32'h7FFF_FFFF);
`else
    check("t5_max_value", obs_q[0], 32'hFFE7_0000);
`endif

    // randomized passes, including a one-column window slide
    for (int pass = 0; pass < 4; pass++) begin
      int nk;
      nk = $urandom_range(1, 4);
      do_clear();
      for (int i = 0; i < nk*KS; i++) load_knl($urandom);
      for (int i = 0; i < KS; i++) load_win($urandom);
      fill_ps_random();
      run_pass(nk, 1'($urandom_range(0, 1)), 1);
      for (int i = 0; i < KH; i++) load_win($urandom);
      fill_ps_random();
      run_pass($urandom_range(1, nk), 1'($urandom_range(0, 1)), 1);
    end

    // clear mid-run with a full kernel store
    do_clear();
    for (int i = 0; i < KM*KS; i++) load_knl($urandom);
    check("knl_store_full_ready", ld_knl_ready, 1'b0);
    for (int i = 0; i < KS; i++) load_win($urandom);
    out_ready = 1'b1;
    num_knls = CW'(KM);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("run_before_clear", out_valid, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    km.delete();
    wm.delete();
    check("clear_out_valid", out_valid, 1'b0);
    check("clear_busy", busy, 1'b0);
    check("clear_knl_ready", ld_knl_ready, 1'b1);
    tick();
    check("clear_no_late_valid", out_valid, 1'b0);
    for (int i = 0; i < KS; i++) load_win($urandom);
    expect_start_err(1, "after_clear");

    // asynchronous reset mid-run
    for (int i = 0; i < KM*KS; i++) load_knl($urandom);
    for (int i = 0; i < KS; i++) load_win($urandom);
    num_knls = CW'(KM);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("run_before_reset", busy, 1'b1);
    srstn = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_knl_ready", ld_knl_ready, 1'b1);
    tick();
    srstn = 1'b1;
    km.delete();
    wm.delete();
    tick();
    check("reset_no_late_valid", out_valid, 1'b0);
    for (int i = 0; i < KS; i++) load_win($urandom);
    expect_start_err(1, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_mac_engine.md
Name: conv_mac_engine

Overview:
Parametrised successor of the fixed 5x5 convolution MAC. It holds up to KNL_MAXNUM kernels of any KNL_HEIGHT x KNL_WIDTH and a sliding input window. On each start it computes one fixed-point dot product per active output channel, through a 2-stage pipeline with a valid/ready output handshake. It sits between the DRAM-side conv controller, which streams kernels, window words and partial sums, and the output writeback.

Parameters:
DATA_WIDTH, 32, signed fixed-point word width
FRAC_BITS, 16, fractional bits; product is arithmetic-shifted right by this amount
KNL_WIDTH, 5, kernel columns
KNL_HEIGHT, 5, kernel rows
KNL_MAXNUM, 16, maximum stored kernels (output channels)
(derived) KSIZE = KNL_WIDTH*KNL_HEIGHT; CW = $clog2(KNL_MAXNUM+1)

Ports:
clk  in  1  clock
srstn  in  1  asynchronous active-low reset
clear  in  1  sync: empty kernel store and window, abort run, go IDLE
ld_knl_valid  in  1  kernel word valid
ld_knl_data  in  DATA_WIDTH  kernel word
ld_knl_ready  out  1  = IDLE && knl_cnt < KNL_MAXNUM*KSIZE
ld_win_valid  in  1  window word valid
ld_win_data  in  DATA_WIDTH  window word
ld_win_ready  out  1  = IDLE
num_knls  in  CW  active channels; sampled on start
start  in  1  begin one window pass (IDLE only)
start_err  out  1  registered 1-cycle pulse: start rejected
acc_en  in  1  add psum_in to output
psum_in  in  DATA_WIDTH  partial sum for channel out_chnl, stable while out_valid
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_data  out  DATA_WIDTH  mac_reg, plus psum_in if acc_en
out_chnl  out  CW  channel index of out_data
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, knl_cnt=0, win_cnt=0, pipeline valids 0, mac_reg=0, out_chnl=0, start_err=0. Storage arrays are not reset.
- Kernel load: each valid&&ready writes word knl_cnt and increments it. Kernel c occupies words c*KSIZE..c*KSIZE+KSIZE-1. Word k is row k/KNL_WIDTH, column k%KNL_WIDTH (row-major).
- Window load: shift register. A new word enters slot KSIZE-1 and all slots move down by one. Slot w is row w%KNL_HEIGHT, column w/KNL_HEIGHT (column-major). Shifting in KNL_HEIGHT words slides the window one column. win_cnt saturates at KSIZE; the window is full when win_cnt==KSIZE.
- start in IDLE is accepted only if the window is full and 1 <= num_knls <= knl_cnt/KSIZE. Otherwise start_err pulses the next cycle and the state stays IDLE. start outside IDLE is ignored, with no error.
- FSM: IDLE -> RUN on accepted start (ch=0, n=num_knls).
  - RUN: issue channel ch into stage 1 each non-stalled cycle, ch++.
  - After issuing n-1, go to DRAIN.
  - DRAIN -> IDLE once the last result handshakes.
- Pipeline:
  - S1 registers KSIZE products. Each product is a full 2*DATA_WIDTH signed multiply, arithmetic-shifted right by FRAC_BITS, then truncated to DATA_WIDTH.
  - S2 sums the KSIZE terms into mac_reg, modulo 2^DATA_WIDTH, and sets out_valid.
  - First out_valid appears 2 cycles after start is accepted. Throughput is 1 channel/cycle without backpressure.
- Backpressure: out_valid && !out_ready stalls S1, S2 and issue. out_data and out_chnl are held stable.
- out_chnl increments 0..n-1 in order. The acc_en add is combinational and wraps modulo 2^DATA_WIDTH.
- Loads are refused (ready=0) outside IDLE. The window and kernels are unchanged during a run.
- clear has priority over all other inputs. It clears counts, valids and state in the same cycle, with no output for the aborted channels.
- Asserting srstn low mid-run behaves like reset; the run is lost.

Optional Feature:
CONV_SAT_EN
- Defined: each shifted product saturates to the signed DATA_WIDTH range. The sum is accumulated at full width and saturated. The psum add also saturates.
- Undefined: truncate and wrap, bit-exact with the existing engine.

Test Plan:
- 25 kernel words of 0x00010000, 25 window words of 0x00020000, num_knls=1, start -> out_data=0x00320000 (50.0), out_chnl=0, 2 cycles after start.
- Kernel all 0xFFFF0000 (-1.0), window all 0x00008000 (0.5) -> 0xFFF38000 (-12.5). Same with acc_en=1, psum_in=0x000D0000 -> 0x00008000.
- Load 3 kernels (k words = 1.0, 2.0, 3.0), window all 1.0, num_knls=3, out_ready low 4 cycles after first valid -> 0x00190000, 0x00320000, 0x004B0000 on chnl 0,1,2. Values held during the stall, no loss or duplication, busy falls after the third handshake.
- start with win_cnt=24, or num_knls=2 with only 1 kernel loaded, or num_knls=0 -> start_err 1-cycle pulse, no out_valid, busy stays 0.
- Kernel and window all 0x7FFFFFFF -> 0xFFE70000 without CONV_SAT_EN; 0x7FFFFFFF with CONV_SAT_EN.
- clear, then srstn low, each asserted mid-run with 16 kernels -> out_valid=0 next cycle, IDLE, ld_knl_ready=1, knl_cnt=0. A subsequent start pulses start_err.
